// File: rtl/mean_pkg.sv
// Shared parameters and types for the boxcar mean filter and its inverse.
// The filter and the recovery block must agree on DEPTH/WIDTH/LOG2, so both
// take their defaults from here.
//   MEAN_DEPTH : window length N, always 2**MEAN_LOG2
//   MEAN_WIDTH : unsigned sample width in bits
//   MEAN_LOG2  : log2(MEAN_DEPTH), sets the pointer width and the sum growth
//   sample_t   : one raw sample
//   sum_t      : full-precision running window sum
package mean_pkg;

  localparam int MEAN_DEPTH = 16;
  localparam int MEAN_WIDTH = 8;
  localparam int MEAN_LOG2  = 4;

  typedef logic [MEAN_WIDTH-1:0]           sample_t;
  typedef logic [MEAN_WIDTH+MEAN_LOG2-1:0] sum_t;

endpackage

// File: rtl/mean_window_buf.sv
// Circular history of the last DEPTH recovered samples.
// One read-before-write port: rd_data_o always shows the entry at the current
// write pointer, which is the sample that is about to leave the window
// (x[n-N]). On a write the same entry is overwritten with the newest sample
// and the pointer advances, wrapping from DEPTH-1 to 0.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears pointer and every entry
//   wr_en_i    : store wr_data_i at the pointer and advance the pointer
//   wr_data_i  : newest recovered sample
//   rd_data_o  : pre-write contents of the entry at the pointer
module mean_window_buf
  import mean_pkg::*;
#(
  parameter int DEPTH = MEAN_DEPTH,
  parameter int WIDTH = MEAN_WIDTH,
  parameter int LOG2  = MEAN_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [LOG2-1:0]  wr_ptr_q;
  logic [LOG2-1:0]  wr_ptr_d;

  // DEPTH is a power of two, so the natural LOG2-bit rollover is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + LOG2'(1);
  end

  // The read is combinational off the registered array, so a write in the
  // same cycle cannot affect what rd_data_o shows until the next cycle.
  assign rd_data_o = hist_q[wr_ptr_q];

  // History entries and pointer; every entry is cleared so the window
  // starts all-zero, matching the upstream filter after its reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      hist_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q         <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/mean_recover.sv
// Inverse of the boxcar mean filter: rebuilds raw samples from the running
// window sum S[n] using x[n] = S[n] - S[n-1] + x[n-N].
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   sum_in     : running window sum S[n], unsigned, WIDTH+LOG2 bits
//   in_valid   : sum_in carries a new sum this cycle
//   out        : recovered sample x[n], one cycle after its sum
//   out_valid  : one-cycle pulse per accepted sum
//   err        : sticky, set when a recovered value fell outside the sample
//                range and was saturated
module mean_recover
  import mean_pkg::*;
#(
  parameter int DEPTH = MEAN_DEPTH,
  parameter int WIDTH = MEAN_WIDTH,
  parameter int LOG2  = MEAN_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH+LOG2-1:0] sum_in,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic                 err
);

  // Two extra bits: one for sign, one for the headroom of adding x[n-N]
  // to a difference that can already span the full sum range.
  localparam int DW = WIDTH + LOG2 + 2;
  localparam logic signed [DW-1:0] SAMPLE_MAX = DW'((1 << WIDTH) - 1);

  logic [WIDTH+LOG2-1:0] prev_sum_q;
  logic [WIDTH-1:0]      out_q;
  logic                  out_valid_q;
  logic                  err_q;

  logic [WIDTH-1:0]      old_sample;
  logic signed [DW-1:0]  diff;
  logic [WIDTH-1:0]      sample_d;
  logic                  range_err;

  mean_window_buf #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LOG2  (LOG2)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (in_valid),
    .wr_data_i (sample_d),
    .rd_data_o (old_sample)
  );

  // Difference plus the sample leaving the window, all zero-extended so the
  // arithmetic never wraps; then clamp into the sample range. The clamped
  // value is what enters the history, keeping it consistent with out.
  always_comb begin
    diff = $signed({2'b00, sum_in}) - $signed({2'b00, prev_sum_q})
         + $signed({{(LOG2 + 2){1'b0}}, old_sample});
    sample_d  = diff[WIDTH-1:0];
    range_err = 1'b0;
    if (diff[DW-1]) begin
      sample_d  = '0;
      range_err = 1'b1;
    end else if (diff > SAMPLE_MAX) begin
      sample_d  = '1;
      range_err = 1'b1;
    end
  end

  // Output, previous-sum and sticky error registers. Without a valid input
  // everything holds except the out_valid pulse, so gaps are free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sum_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        prev_sum_q <= sum_in;
        out_q      <= sample_d;
        err_q      <= err_q | range_err;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mean_recover.sv
// Self-checking bench for mean_recover. The reference is a forward model of
// the boxcar filter: the bench picks raw samples, forms their window sum with
// a queue, feeds the sum, and expects the raw sample back one cycle later.
// Out-of-range cases are checked against directed constants.
module tb_mean_recover;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int LOG2  = 4;

  logic                  clk;
  logic                  rst_n;
  logic [WIDTH+LOG2-1:0] sum_in;
  logic                  in_valid;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic                  err;

  int checkCount = 0;
  int passCount  = 0;

  // Filter-side model state: last DEPTH raw samples, last delivered sample.
  int window[$];
  int lastOut;

  mean_recover #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LOG2  (LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of input at the falling edge, then let the rising edge
  // take it and sample the registered outputs shortly afterwards.
  task automatic applyStimulus(input logic valid, input int sumValue);
    @(negedge clk);
    in_valid = valid;
    sum_in   = (WIDTH+LOG2)'(sumValue);
    @(posedge clk);
    #1;
  endtask

  // Reset both the DUT and the filter model.
  task automatic doReset();
    @(negedge clk);
    in_valid = 1'b0;
    sum_in   = '0;
    rst_n    = 1'b0;
    #12;
    checkOutput("reset out", 32'(out), 0);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    window.delete();
    for (int i = 0; i < DEPTH; i++) window.push_back(0);
    lastOut = 0;
  endtask

  // Pass one raw sample through the filter model and check its recovery.
  task automatic sendSample(input string tag, input int x, input logic expErr);
    int s;
    window.push_back(x);
    void'(window.pop_front());
    s = 0;
    foreach (window[i]) s += window[i];
    applyStimulus(1'b1, s);
    lastOut = x;
    checkOutput({tag, " out"}, 32'(out), 32'(x));
    checkOutput({tag, " out_valid"}, 32'(out_valid), 1);
    checkOutput({tag, " err"}, 32'(err), 32'(expErr));
  endtask

  // An idle cycle with a junk sum: everything must hold.
  task automatic sendGap(input string tag);
    applyStimulus(1'b0, int'($urandom_range(0, 4095)));
    checkOutput({tag, " gap out"}, 32'(out), 32'(lastOut));
    checkOutput({tag, " gap out_valid"}, 32'(out_valid), 0);
  endtask

  int stepSamples[] = '{128, 124, 127, 120, 110, 96, 80, 64, 200, 255,
                        0, 33, 17, 250, 5, 90, 60, 30, 1, 254};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sum_in   = '0;

    // Reset and a run of zero sums.
    doReset();
    for (int i = 0; i < 20; i++) sendSample("zeros", 0, 1'b0);

    // Constant ones: sums ramp 1..16 then hold at 16, across the pointer wrap.
    doReset();
    for (int i = 0; i < 36; i++) sendSample("const", 1, 1'b0);

    // Step and decay, then drain the window.
    doReset();
    foreach (stepSamples[i]) sendSample("step", stepSamples[i], 1'b0);
    for (int i = 0; i < DEPTH; i++) sendSample("drain", 0, 1'b0);
    applyStimulus(1'b1, 0);
    checkOutput("final zero out", 32'(out), 0);

    // Same stream with idle cycles in between.
    doReset();
    foreach (stepSamples[i]) begin
      sendSample("gapstep", stepSamples[i], 1'b0);
      sendGap("gapstep");
    end
    for (int i = 0; i < DEPTH; i++) begin
      sendSample("gapdrain", 0, 1'b0);
      sendGap("gapdrain");
    end

    // Random samples with random gaps, weighted toward the range edges.
    doReset();
    for (int i = 0; i < 300; i++) begin
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      sendGap("rand");
      else if (pick == 1) sendSample("rand", 0, 1'b0);
      else if (pick == 2) sendSample("rand", 255, 1'b0);
      else                sendSample("rand", int'($urandom_range(0, 255)), 1'b0);
    end

    // Overflow: a sum no valid window can produce.
    doReset();
    applyStimulus(1'b1, 300);
    checkOutput("over out", 32'(out), 255);
    checkOutput("over err", 32'(err), 1);

    // Underflow: sum falls by more than the departing sample.
    doReset();
    applyStimulus(1'b1, 5);
    checkOutput("under first out", 32'(out), 5);
    checkOutput("under first err", 32'(err), 0);
    applyStimulus(1'b1, 0);
    checkOutput("under out", 32'(out), 0);
    checkOutput("under err", 32'(err), 1);
    // d = 0 - 0 + 5 = 5 with the first sample now leaving? No: history slot 2
    // is still zero, so a zero sum recovers 0 and err must stay set.
    applyStimulus(1'b1, 0);
    checkOutput("sticky out", 32'(out), 0);
    checkOutput("sticky out_valid", 32'(out_valid), 1);
    checkOutput("sticky err", 32'(err), 1);
    applyStimulus(1'b0, 0);
    checkOutput("sticky gap err", 32'(err), 1);

    // Mid-stream reset at input 9 of the constant stream, then restart.
    doReset();
    for (int i = 0; i < 8; i++) sendSample("mid", 1, 1'b0);
    doReset();
    for (int i = 0; i < 20; i++) sendSample("restart", 1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
